// File: rtl/shiftreg_loader.sv
// Serial loader for the static and dynamic configuration chains: it shifts each chain MSB-first over one shared line, then latches.
// Optional feature: define SHIFTREG_LOADER_DYN_ONLY_EN to add the dyn_only port, which skips the static chain.
module shiftreg_loader #(
  parameter int STAT_W    = 88,
  parameter int DYN_W     = 16,
  parameter int WAIT1_CYC = 8,
  parameter int WAIT2_CYC = 128,
  parameter int CNT_W     = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [STAT_W-1:0] stat_data,
  input  logic [DYN_W-1:0]  dyn_data,
`ifdef SHIFTREG_LOADER_DYN_ONLY_EN
  input  logic              dyn_only,
`endif
  output logic              sdo,
  output logic              sel_stat,
  output logic              sel_dyn,
  output logic              latch,
  output logic              busy,
  output logic              en_fin
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_1     = 3'd1;
  localparam logic [2:0] S_SHIFT_STAT = 3'd2;
  localparam logic [2:0] S_SHIFT_DYN  = 3'd3;
  localparam logic [2:0] S_LATCH      = 3'd4;
  localparam logic [2:0] S_WAIT_2     = 3'd5;

  localparam logic [CNT_W-1:0] L_W1   = CNT_W'(WAIT1_CYC - 1);
  localparam logic [CNT_W-1:0] L_STAT = CNT_W'(STAT_W - 1);
  localparam logic [CNT_W-1:0] L_DYN  = CNT_W'(DYN_W - 1);
  localparam logic [CNT_W-1:0] L_W2   = CNT_W'(WAIT2_CYC - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [STAT_W-1:0] r_stat;
  logic [DYN_W-1:0]  r_dyn;
  logic              r_sdo, r_sel_stat, r_sel_dyn, r_latch, r_busy, r_en_fin;

  logic [2:0] w_nxt;
  logic       w_capture;
  logic       w_fin;
  logic       w_dyn_only;

`ifdef SHIFTREG_LOADER_DYN_ONLY_EN
  logic r_dyn_only;
  assign w_dyn_only = r_dyn_only;
`else
  assign w_dyn_only = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:       if (start) w_nxt = S_WAIT_1;
      S_WAIT_1:     if (r_cnt == L_W1) w_nxt = w_dyn_only ? S_SHIFT_DYN : S_SHIFT_STAT;
      S_SHIFT_STAT: if (r_cnt == L_STAT) w_nxt = S_SHIFT_DYN;
      S_SHIFT_DYN:  if (r_cnt == L_DYN) w_nxt = S_LATCH;
      S_LATCH:      w_nxt = S_WAIT_2;
      S_WAIT_2:     if (r_cnt == L_W2) w_nxt = continuous ? S_WAIT_1 : S_IDLE;
      default:      w_nxt = S_IDLE;
    endcase
    // abort outranks both normal completion and a continuous restart
    if (abort && r_state != S_IDLE) w_nxt = S_IDLE;
  end

  // Capture happens on the initial start and on every continuous restart.
  assign w_capture = (w_nxt == S_WAIT_1) && (r_state == S_IDLE || r_state == S_WAIT_2);
  assign w_fin     = (r_state == S_WAIT_2) && (r_cnt == L_W2) && !abort;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_stat     <= '0;
      r_dyn      <= '0;
      r_sdo      <= 1'b0;
      r_sel_stat <= 1'b0;
      r_sel_dyn  <= 1'b0;
      r_latch    <= 1'b0;
      r_busy     <= 1'b0;
      r_en_fin   <= 1'b0;
`ifdef SHIFTREG_LOADER_DYN_ONLY_EN
      r_dyn_only <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);

      if (w_capture) begin
        r_stat <= stat_data;
        r_dyn  <= dyn_data;
      end else if (w_nxt == S_SHIFT_STAT) begin
        r_stat <= r_stat << 1;
      end else if (w_nxt == S_SHIFT_DYN) begin
        r_dyn <= r_dyn << 1;
      end
`ifdef SHIFTREG_LOADER_DYN_ONLY_EN
      if (r_state == S_IDLE && start) r_dyn_only <= dyn_only;
`endif

      // Outputs are decoded from the next state so they line up with the state they describe.
      r_sel_stat <= (w_nxt == S_SHIFT_STAT);
      r_sel_dyn  <= (w_nxt == S_SHIFT_DYN);
      r_sdo      <= (w_nxt == S_SHIFT_STAT) ? r_stat[STAT_W-1] :
                    (w_nxt == S_SHIFT_DYN)  ? r_dyn[DYN_W-1]   : 1'b0;
      r_latch    <= (w_nxt == S_LATCH);
      r_busy     <= (w_nxt != S_IDLE);

      if (w_fin)
        r_en_fin <= 1'b1;
      else if (r_state == S_IDLE && start)
        r_en_fin <= 1'b0;
      else if (abort && r_state != S_IDLE)
        r_en_fin <= 1'b0;
    end
  end

  assign sdo      = r_sdo;
  assign sel_stat = r_sel_stat;
  assign sel_dyn  = r_sel_dyn;
  assign latch    = r_latch;
  assign busy     = r_busy;
  assign en_fin   = r_en_fin;

endmodule
